// File: rtl/input_control_pkg.sv
// input_control_pkg: shared types and helpers for the input_control slice.
//   btn_idx_t    : bit position of each raw button inside btn[7:0]
//   key_state_t  : auto-repeat FSM state (debug-visible)
//   grav_period(): gravity period in clock cycles for a given level
package input_control_pkg;

  typedef enum logic [2:0] {
    LEFT    = 3'd0,
    RIGHT   = 3'd1,
    ROT_C   = 3'd2,
    ROT_CC  = 3'd3,
    DOWN    = 3'd4,
    HARD    = 3'd5,
    PAUSE   = 3'd6,
    NEWGAME = 3'd7
  } btn_idx_t;

  typedef enum logic [1:0] {
    KR_IDLE = 2'd0,
    KR_DAS  = 2'd1,
    KR_REP  = 2'd2
  } key_state_t;

  // Period shrinks linearly with level: base - level * step.
  function automatic logic [31:0] grav_period(input logic [3:0]  level,
                                              input logic [31:0] base,
                                              input logic [31:0] step);
    return base - ({28'd0, level} * step);
  endfunction

endpackage

// File: rtl/input_control_key_repeat.sv
// input_control_key_repeat: DAS/ARR auto-repeat for one debounced key.
//   clk, reset : clock, synchronous active-high reset
//   press      : 1-cycle debounced 0->1 edge of the key
//   held       : debounced key level
//   hold_idle  : forces the FSM to IDLE (no repeats while asserted)
//   pulse      : combinational 1-cycle request (registered by the parent)
//   state      : current FSM state, exposed for debug
module input_control_key_repeat
  import input_control_pkg::*;
#(
  parameter int unsigned DAS_CYC = 8_000_000,
  parameter int unsigned ARR_CYC = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic       held,
  input  logic       hold_idle,
  output logic       pulse,
  output key_state_t state
);

  localparam logic [31:0] DAS_LAST = DAS_CYC - 1;
  localparam logic [31:0] ARR_LAST = ARR_CYC - 1;

  key_state_t  state_n;
  logic [31:0] cnt;
  logic [31:0] cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= KR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse   = 1'b0;
    case (state)
      KR_IDLE: begin
        cnt_n = '0;
        // The initial press always produces its pulse; hold_idle only
        // prevents the FSM from arming the repeat.
        if (press) begin
          pulse = 1'b1;
          if (!hold_idle) state_n = KR_DAS;
        end
      end
      KR_DAS: begin
        if (!held || hold_idle) begin
          state_n = KR_IDLE;
          cnt_n   = '0;
        end else if (cnt == DAS_LAST) begin
          pulse   = 1'b1;
          state_n = KR_REP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      KR_REP: begin
        if (!held || hold_idle) begin
          state_n = KR_IDLE;
          cnt_n   = '0;
        end else if (cnt == ARR_LAST) begin
          pulse = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: begin
        state_n = KR_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/input_control.sv
// input_control: producer side of the game_control command interface.
// Debounces the raw buttons, turns presses into 1-cycle command pulses,
// auto-repeats left/right/soft-drop, and owns the gravity timer.
// Optional feature macro: AUTO_REPEAT_EN (DAS/ARR repeat; when undefined
// each press of left/right/down yields exactly one pulse).
//   clk, reset           : clock, synchronous active-high reset
//   btn[7:0]             : raw active-high buttons, index per btn_idx_t
//   level[3:0]           : current level, selects the gravity period
//   reset_down           : gravity acknowledge, restarts the gravity timer
//   isLost               : game over; only newgame may pulse
//   left, right, rotate_clock, rotate_counter_clock, hard_drop, pause,
//   newgame              : registered 1-cycle pulses
//   down                 : soft-drop pulse OR held gravity request
//   repeat_state[5:0]    : {down, right, left} repeat FSM states (debug)
//
// Gravity handshake: grav_req (visible on down) is the request; reset_down
// is its acknowledge. Once raised, grav_req stays high (even while paused)
// until reset_down is sampled high; an acknowledge in the same cycle as a
// new request clears it.
module input_control
  import input_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 500_000,
`ifdef AUTO_REPEAT_EN
  parameter int unsigned DAS_CYC       = 8_000_000,
  parameter int unsigned ARR_CYC       = 2_500_000,
`endif
  parameter int unsigned GRAV_BASE_CYC = 50_000_000,
  parameter int unsigned GRAV_STEP_CYC = 3_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn,
  input  logic [3:0] level,
  input  logic       reset_down,
  input  logic       isLost,
  output logic       left,
  output logic       right,
  output logic       rotate_clock,
  output logic       rotate_counter_clock,
  output logic       down,
  output logic       hard_drop,
  output logic       pause,
  output logic       newgame,
  output logic [5:0] repeat_state
);

  localparam logic [31:0] DB_LAST = DEBOUNCE_CYC - 1;

  logic [7:0]  sync1, sync2, stable, stable_q;
  logic [31:0] db_cnt [8];
  logic [7:0]  press;

  // 2-FF synchroniser, then a per-bit debouncer: the accepted level only
  // flips after DEBOUNCE_CYC consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 32'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  // Same-cycle conflicts: left wins over right, clockwise over counter.
  logic press_left, press_right;
  assign press_left  = press[LEFT] & ~isLost;
  assign press_right = press[RIGHT] & ~press[LEFT] & ~isLost;

  logic left_p, right_p, soft_p;

`ifdef AUTO_REPEAT_EN
  logic       lr_both;
  key_state_t left_st, right_st, down_st;

  // Opposite directions held together freeze both repeaters.
  assign lr_both = stable[LEFT] & stable[RIGHT];

  input_control_key_repeat #(.DAS_CYC(DAS_CYC), .ARR_CYC(ARR_CYC)) u_rep_left (
    .clk(clk), .reset(reset), .press(press_left), .held(stable[LEFT]),
    .hold_idle(lr_both | isLost), .pulse(left_p), .state(left_st)
  );

  input_control_key_repeat #(.DAS_CYC(DAS_CYC), .ARR_CYC(ARR_CYC)) u_rep_right (
    .clk(clk), .reset(reset), .press(press_right), .held(stable[RIGHT]),
    .hold_idle(lr_both | isLost), .pulse(right_p), .state(right_st)
  );

  input_control_key_repeat #(.DAS_CYC(DAS_CYC), .ARR_CYC(ARR_CYC)) u_rep_down (
    .clk(clk), .reset(reset), .press(press[DOWN] & ~isLost), .held(stable[DOWN]),
    .hold_idle(isLost), .pulse(soft_p), .state(down_st)
  );

  assign repeat_state = {down_st, right_st, left_st};
`else
  assign left_p       = press_left;
  assign right_p      = press_right;
  assign soft_p       = press[DOWN];
  assign repeat_state = 6'd0;
`endif

  // Gravity timer.
  logic [31:0] grav_cnt, grav_cnt_n, period_m1;
  logic        grav_req, grav_req_n;
  logic        paused, paused_n;

  assign period_m1 = grav_period(level, GRAV_BASE_CYC, GRAV_STEP_CYC) - 32'd1;

  always_comb begin
    paused_n   = paused;
    grav_cnt_n = grav_cnt;
    grav_req_n = grav_req;
    if (press[NEWGAME]) begin
      paused_n   = 1'b0;
      grav_cnt_n = '0;
      grav_req_n = 1'b0;
    end else begin
      if (press[PAUSE] && !isLost) paused_n = ~paused;
      if (reset_down) begin
        grav_cnt_n = '0;
        grav_req_n = 1'b0;
      end else if (!paused && !isLost) begin
        // >= so that a level increase past the current count fires at once.
        if (grav_cnt >= period_m1) begin
          grav_req_n = 1'b1;
          grav_cnt_n = '0;
        end else begin
          grav_cnt_n = grav_cnt + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grav_cnt             <= '0;
      grav_req             <= 1'b0;
      paused               <= 1'b0;
      left                 <= 1'b0;
      right                <= 1'b0;
      rotate_clock         <= 1'b0;
      rotate_counter_clock <= 1'b0;
      down                 <= 1'b0;
      hard_drop            <= 1'b0;
      pause                <= 1'b0;
      newgame              <= 1'b0;
    end else begin
      grav_cnt             <= grav_cnt_n;
      grav_req             <= grav_req_n;
      paused               <= paused_n;
      left                 <= left_p & ~isLost;
      right                <= right_p & ~isLost;
      rotate_clock         <= press[ROT_C] & ~isLost;
      rotate_counter_clock <= press[ROT_CC] & ~press[ROT_C] & ~isLost;
      down                 <= (grav_req_n | soft_p) & ~isLost;
      hard_drop            <= press[HARD] & ~isLost;
      pause                <= press[PAUSE] & ~press[NEWGAME] & ~isLost;
      newgame              <= press[NEWGAME];
    end
  end

endmodule

// File: tb/tb_input_control.sv
// tb_input_control: self-checking bench for input_control with short
// simulation timing. Pulses are logged as {output index, cycle} events and
// compared against event lists derived from press/release times.
module tb_input_control;

  localparam int DEB  = 4;
  localparam int DAS  = 20;
  localparam int ARR  = 5;
  localparam int GBASE = 100;
  localparam int GSTEP = 5;
  localparam int LAT  = 2 + DEB + 1;   // raw edge to registered pulse

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn;
  logic [3:0] level;
  logic       reset_down, isLost;
  logic       left, right, rotate_clock, rotate_counter_clock;
  logic       down, hard_drop, pause, newgame;
  logic [5:0] repeat_state;
  logic [7:0] outs;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign outs = {newgame, pause, hard_drop, down, rotate_counter_clock,
                 rotate_clock, right, left};

  input_control #(
    .DEBOUNCE_CYC(DEB),
`ifdef AUTO_REPEAT_EN
    .DAS_CYC(DAS),
    .ARR_CYC(ARR),
`endif
    .GRAV_BASE_CYC(GBASE),
    .GRAV_STEP_CYC(GSTEP)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .level(level),
    .reset_down(reset_down), .isLost(isLost),
    .left(left), .right(right), .rotate_clock(rotate_clock),
    .rotate_counter_clock(rotate_counter_clock), .down(down),
    .hard_drop(hard_drop), .pause(pause), .newgame(newgame),
    .repeat_state(repeat_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) begin
    if (mon_en)
      for (int i = 0; i < 8; i++)
        if (outs[i]) got_q.push_back({4'(i), 28'(cyc)});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_exp(input int idx, input int t);
    exp_q.push_back({4'(idx), 28'(t)});
  endtask

  // Expected pulses for one clean hold: first at rise+LAT, then (repeating
  // keys only) DAS later and every ARR after that, as long as the
  // debounced level is still high (it falls DEB+2 cycles after release).
  task automatic add_expected(input int idx, input int tr, input int tf, input bit rep);
    int t;
    t = tr + LAT;
    push_exp(idx, t);
    if (rep && AUTO_REP) begin
      t = t + DAS;
      while (t <= tf + DEB + 2) begin
        push_exp(idx, t);
        t = t + ARR;
      end
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int t0);
    tick(1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic hold_btn(input int idx, input int hold, input bit bounce,
                          output int tr, output int tf);
    tick(1);
    if (bounce) begin
      btn[idx] = 1'b1;
      tick($urandom_range(1, DEB - 1));
      btn[idx] = 1'b0;
      tick($urandom_range(1, 3));
    end
    btn[idx] = 1'b1;
    tr = cyc;
    tick(hold);
    btn[idx] = 1'b0;
    tf = cyc;
  endtask

  task automatic wait_down_rise(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (down) begin
        t = cyc;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t, a, tr, tf, t1, t2, c1, lows, idx, hold;
    reset = 1'b1; btn = '0; level = 4'd0; reset_down = 1'b0; isLost = 1'b0;

    // Reset state
    do_reset(t0);
    check("reset_outs", {24'd0, outs}, 32'd0);
    check("reset_repeat_state", {26'd0, repeat_state}, 32'd0);

    // Gravity at level 0: request after one full period, then held
    wait_down_rise(300, t);
    check("grav_l0_rise", t, t0 + GBASE);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!down) lows++;
    end
    check("grav_held", lows, 0);
    tick(1);
    reset_down = 1'b1;
    a = cyc;
    tick(1);
    reset_down = 1'b0;
    check("grav_ack_low", {31'd0, down}, 32'd0);
    wait_down_rise(300, t);
    check("grav_rearm", t, a + 1 + GBASE);

    // Request stays held across a pause; newgame clears it and unpauses
    hold_btn(6, 10, 1'b0, tr, tf);
    tick(12);
    check("held_while_paused", {31'd0, down}, 32'd1);
    hold_btn(7, 10, 1'b0, tr, tf);
    check("newgame_clears", {31'd0, down}, 32'd0);
    wait_down_rise(300, t);
    check("grav_after_newgame", t, tr + LAT + GBASE);

    // Level 15 period
    level = 4'd15;
    do_reset(t0);
    wait_down_rise(100, t);
    check("grav_l15", t, t0 + GBASE - 15 * GSTEP);

    // Level jump mid-count fires on the next cycle
    level = 4'd0;
    do_reset(t0);
    tick(50);
    level = 4'd15;
    wait_down_rise(100, t);
    check("grav_level_jump", t, t0 + 51);

    // Pause freezes the count, second press resumes from it
    level = 4'd0;
    do_reset(t0);
    tick(30);
    mon_en = 1'b1;
    hold_btn(6, 10, 1'b0, t1, tf);
    tick(12);
    c1 = t1 + LAT - t0;
    tick(170);
    check("pause_frozen", {31'd0, down}, 32'd0);
    hold_btn(6, 10, 1'b0, t2, tf);
    tick(12);
    mon_en = 1'b0;
    push_exp(6, t1 + LAT);
    push_exp(6, t2 + LAT);
    compare_events("pause_pulses");
    wait_down_rise(300, t);
    check("pause_resume", t, t2 + LAT + GBASE - c1);

    // Key tests: gravity held off by a permanent acknowledge
    reset_down = 1'b1;
    do_reset(t0);
    mon_en = 1'b1;

    // Short bounces never register
    tick(1);
    btn[0] = 1'b1; tick(3); btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1; tick(2); btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1; tick(1); btn[0] = 1'b0; tick(12);
    compare_events("left_bounce");

    hold_btn(0, 12, 1'b0, tr, tf);
    tick(12);
    add_expected(0, tr, tf, 1'b1);
    compare_events("left_single");

    hold_btn(1, 60, 1'b0, tr, tf);
    tick(12);
    add_expected(1, tr, tf, 1'b1);
    compare_events("right_repeat");

    // Simultaneous left/right: left only, no repeats
    tick(1);
    btn[1:0] = 2'b11;
    tr = cyc;
    tick(40);
    btn[1:0] = 2'b00;
    tick(12);
    push_exp(0, tr + LAT);
    compare_events("left_beats_right");

    // Simultaneous rotations: clockwise only
    tick(1);
    btn[3:2] = 2'b11;
    tr = cyc;
    tick(8);
    btn[3:2] = 2'b00;
    tick(12);
    push_exp(2, tr + LAT);
    compare_events("rot_conflict");

    // Game over: only newgame pulses
    isLost = 1'b1;
    foreach (exp_q[i]) exp_q.delete(i);
    hold_btn(0, 30, 1'b0, tr, tf); tick(12);
    hold_btn(2, 10, 1'b0, tr, tf); tick(12);
    hold_btn(4, 30, 1'b0, tr, tf); tick(12);
    hold_btn(5, 10, 1'b0, tr, tf); tick(12);
    hold_btn(6, 10, 1'b0, tr, tf); tick(12);
    hold_btn(7, 10, 1'b0, tr, tf); tick(12);
    push_exp(7, tr + LAT);
    compare_events("lost_only_newgame");
    isLost = 1'b0;

    // Randomised single-key holds, optionally preceded by a bounce
    for (int it = 0; it < 16; it++) begin
      idx  = $urandom_range(0, 5);
      hold = $urandom_range(DEB + 1, 70);
      hold_btn(idx, hold, 1'($urandom_range(0, 1)), tr, tf);
      tick(12);
      add_expected(idx, tr, tf, (idx == 0) || (idx == 1) || (idx == 4));
      compare_events($sformatf("rand%0d_btn%0d_hold%0d", it, idx, hold));
    end
    mon_en = 1'b0;

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
